// File: rtl/mmcm_reconfig_ctrl.sv
// MMCM dynamic reconfiguration controller: read-modify-writes a ROM profile over DRP
// while holding the MMCM in reset, then gates the core reset on a settled lock.
module mmcm_reconfig_ctrl #(
  parameter int NUM_REGS     = 8,
  parameter int SETTLE       = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int DRP_TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic [1:0]  cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  rom_addr,
  input  logic [38:0] rom_data,
  output logic [6:0]  drp_addr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  output logic        drp_en,
  output logic        drp_we,
  input  logic        drp_rdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked,
  output logic        sys_rst_n
);

  localparam int TMAX = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(SETTLE + 1);
  localparam logic [TW-1:0] DRP_LAST  = TW'(DRP_TIMEOUT - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SETTLE_N  = SW'(SETTLE);
  localparam logic [2:0]    LAST_IDX  = 3'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, FETCH, RD, WAIT_RD, WR, WAIT_WR, RELEASE, WAIT_LOCK
  } state_t;

  state_t        state;
  logic          lock_meta, lock_sync;
  logic [1:0]    sel;
  logic [2:0]    idx;
  logic          fetch_wait;
  logic [15:0]   rom_mask, rom_wdata;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] settle_cnt, settle_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= mmcm_locked;
      lock_sync <= lock_meta;
    end
  end

  // Settle count only runs while idle with a continuous lock; any drop restarts it.
  always_comb begin
    settle_nxt = '0;
    if (state == IDLE && lock_sync)
      settle_nxt = (settle_cnt == SETTLE_N) ? settle_cnt : settle_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      sys_rst_n  <= 1'b0;
    end else begin
      settle_cnt <= settle_nxt;
      sys_rst_n  <= (state == IDLE) && !cfg_req && (settle_nxt == SETTLE_N);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rom_addr   <= '0;
      drp_addr   <= '0;
      drp_di     <= '0;
      drp_en     <= 1'b0;
      drp_we     <= 1'b0;
      mmcm_rst   <= 1'b0;
      sel        <= '0;
      idx        <= '0;
      fetch_wait <= 1'b0;
      rom_mask   <= '0;
      rom_wdata  <= '0;
      tmo_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cfg_req) begin
          sel      <= cfg_sel;
          err      <= 1'b0;
          idx      <= '0;
          busy     <= 1'b1;
          mmcm_rst <= 1'b1;
          state    <= ASSERT_RST;
        end
        ASSERT_RST: begin
          rom_addr   <= {sel, idx};
          fetch_wait <= 1'b1;
          state      <= FETCH;
        end
        // First FETCH cycle lets the registered ROM catch up; the second consumes its word.
        FETCH: if (fetch_wait) begin
          fetch_wait <= 1'b0;
        end else begin
          drp_addr  <= rom_data[38:32];
          rom_mask  <= rom_data[31:16];
          rom_wdata <= rom_data[15:0];
          drp_en    <= 1'b1;
          drp_we    <= 1'b0;
          state     <= RD;
        end
        RD: begin
          drp_en  <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT_RD;
        end
        WAIT_RD: if (drp_rdy) begin
          drp_di <= (drp_do & rom_mask) | (rom_wdata & ~rom_mask);
          drp_en <= 1'b1;
          drp_we <= 1'b1;
          state  <= WR;
        end else if (tmo_cnt == DRP_LAST) begin
          err      <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          mmcm_rst <= 1'b0;
          state    <= IDLE;
        end else begin
          tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
        end
        WR: begin
          drp_en  <= 1'b0;
          drp_we  <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT_WR;
        end
        WAIT_WR: if (drp_rdy) begin
          idx <= idx + 3'd1;
          if (idx == LAST_IDX) begin
            mmcm_rst <= 1'b0;
            state    <= RELEASE;
          end else begin
            rom_addr   <= {sel, idx + 3'd1};
            fetch_wait <= 1'b1;
            state      <= FETCH;
          end
        end else if (tmo_cnt == DRP_LAST) begin
          err      <= 1'b1;
          done     <= 1'b1;
          busy     <= 1'b0;
          mmcm_rst <= 1'b0;
          state    <= IDLE;
        end else begin
          tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
        end
        RELEASE: begin
          tmo_cnt <= '0;
          state   <= WAIT_LOCK;
        end
        WAIT_LOCK: if (lock_sync) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else if (tmo_cnt == LOCK_LAST) begin
          err   <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          tmo_cnt <= (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Bench for mmcm_reconfig_ctrl: registered ROM, DRP slave with programmable latency,
// MMCM lock model, and a write scoreboard filled as read data is returned.
module tb_mmcm_reconfig_ctrl;
  localparam int NUM_REGS     = 8;
  localparam int SETTLE       = 16;
  localparam int LOCK_TIMEOUT = 100;
  localparam int DRP_TIMEOUT  = 64;
  localparam int LOCK_DELAY   = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_req;
  logic [1:0]  cfg_sel;
  logic        busy, done, err;
  logic [4:0]  rom_addr;
  logic [38:0] rom_data;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di;
  wire  [15:0] drp_do;
  logic        drp_en, drp_we, drp_rdy;
  logic        mmcm_rst;
  wire         mmcm_locked;
  logic        sys_rst_n;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] rd_val;
    logic [15:0] mask;
    logic [15:0] data;
    logic [15:0] exp_di;
    int          lat;
  } vec_t;

  typedef struct {
    logic [6:0]  addr;
    logic [15:0] di;
  } exp_t;

  vec_t        vecs[4];
  vec_t        cur;
  exp_t        sb[$];
  logic [38:0] rom[32];
  logic        lock_force, lock_val, auto_locked, rdy_enable;
  int          checks = 0;
  int          errors = 0;
  int          rd_total = 0;
  int          wr_total = 0;

  assign mmcm_locked = lock_force ? lock_val : auto_locked;
  assign drp_do      = cur.rd_val;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  mmcm_reconfig_ctrl #(
    .NUM_REGS(NUM_REGS), .SETTLE(SETTLE),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .DRP_TIMEOUT(DRP_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
    .busy(busy), .done(done), .err(err),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do),
    .drp_en(drp_en), .drp_we(drp_we), .drp_rdy(drp_rdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked), .sys_rst_n(sys_rst_n)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_err"}, err, 0);
    checkOutput({tag, "_drp_en"}, drp_en, 0);
    checkOutput({tag, "_drp_we"}, drp_we, 0);
    checkOutput({tag, "_drp_addr"}, drp_addr, 0);
    checkOutput({tag, "_drp_di"}, drp_di, 0);
    checkOutput({tag, "_rom_addr"}, rom_addr, 0);
    checkOutput({tag, "_mmcm_rst"}, mmcm_rst, 0);
    checkOutput({tag, "_sys_rst_n"}, sys_rst_n, 0);
  endtask

  task automatic loadProfile(input int vi);
    cur = vecs[vi];
    for (int i = 0; i < NUM_REGS; i++)
      rom[{vecs[vi].sel, 3'(i)}] = {2'b10, vecs[vi].sel, 3'(i), vecs[vi].mask, vecs[vi].data};
  endtask

  // Starts a reconfiguration and waits (bounded) for its done pulse.
  task automatic applyStimulus(input int vi, output int en_to_done, output int rel_to_done);
    int n, first_en, fall;
    bit got;
    loadProfile(vi);
    @(negedge clk);
    cfg_sel = vecs[vi].sel;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    checkOutput("busy_on_start", busy, 1);
    checkOutput("mmcm_rst_on_start", mmcm_rst, 1);
    checkOutput("sys_rst_n_on_start", sys_rst_n, 0);
    n = 0; first_en = -1; fall = -1; got = 1'b0;
    while (n < 3000 && !got) begin
      @(negedge clk);
      n++;
      if (drp_en && first_en < 0) first_en = n;
      if (!mmcm_rst && fall < 0) fall = n;
      if (done) got = 1'b1;
    end
    checkOutput("done_seen", got, 1);
    en_to_done  = n - first_en;
    rel_to_done = n - fall;
    checkOutput("busy_at_done", busy, 0);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
  endtask

  task automatic waitSysRelease(input string name);
    int n = 0;
    while (!sys_rst_n && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, sys_rst_n, 1);
  endtask

  // DRP slave and MMCM lock model; expected writes are queued when read data is returned.
  initial begin
    int rdy_cnt, rd_idx, lock_cnt;
    bit pending;
    exp_t e;
    drp_rdy = 1'b0; auto_locked = 1'b1; lock_cnt = LOCK_DELAY;
    pending = 1'b0; rdy_cnt = 0; rd_idx = 0;
    forever begin
      @(negedge clk);
      drp_rdy = 1'b0;
      if (mmcm_rst) begin
        lock_cnt = 0;
        auto_locked = 1'b0;
      end else if (lock_cnt < LOCK_DELAY) begin
        lock_cnt++;
        auto_locked = (lock_cnt == LOCK_DELAY);
      end
      if (!rst_n || !busy) begin
        pending = 1'b0;
        rd_idx = 0;
        sb.delete();
      end else begin
        if (pending) begin
          rdy_cnt--;
          if (rdy_cnt == 0) begin
            drp_rdy = 1'b1;
            pending = 1'b0;
          end
        end
        if (drp_en) begin
          checkOutput("drp_en_while_pending", pending, 0);
          checkOutput("mmcm_rst_during_drp", mmcm_rst, 1);
          if (!drp_we) begin
            checkOutput("rom_addr_order", rom_addr, {cur.sel, 3'(rd_idx)});
            checkOutput("rd_drp_addr", drp_addr, {2'b10, cur.sel, 3'(rd_idx)});
            e.addr = {2'b10, cur.sel, 3'(rd_idx)};
            e.di   = cur.exp_di;
            sb.push_back(e);
            rd_idx++;
            rd_total++;
          end else begin
            checkOutput("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              checkOutput("wr_drp_addr", drp_addr, e.addr);
              checkOutput("wr_drp_di", drp_di, e.di);
            end
            wr_total++;
          end
          if (rdy_enable) begin
            pending = 1'b1;
            rdy_cnt = cur.lat;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 300000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e2d, r2d, rd0, wr0, low_cnt, n;
    bit saw, seen_busy, found;

    vecs[0] = '{sel: 2'd2, rd_val: 16'hAAAA, mask: 16'hFF00, data: 16'h1234, exp_di: 16'hAA34, lat: 3};
    vecs[1] = '{sel: 2'd0, rd_val: 16'h0F0F, mask: 16'h00FF, data: 16'hFFFF, exp_di: 16'hFF0F, lat: 1};
    vecs[2] = '{sel: 2'd1, rd_val: 16'hFFFF, mask: 16'h0000, data: 16'h5A5A, exp_di: 16'h5A5A, lat: 2};
    vecs[3] = '{sel: 2'd3, rd_val: 16'h1234, mask: 16'hF0F0, data: 16'hABCD, exp_di: 16'h1B3D, lat: 5};
    for (int i = 0; i < 32; i++) rom[i] = '0;
    cur = vecs[0];

    rst_n = 1'b0; cfg_req = 1'b0; cfg_sel = 2'd0;
    lock_force = 1'b1; lock_val = 1'b1; rdy_enable = 1'b1;
    repeat (3) @(negedge clk);
    checkResetValues("por");

    // Power-up with lock already present.
    rst_n = 1'b1;
    for (int k = 1; k <= SETTLE + 2; k++) begin
      @(negedge clk);
      if (k == SETTLE + 1) checkOutput("pwrup_sys_rst_n_early", sys_rst_n, 0);
      if (k == SETTLE + 2) begin
        checkOutput("pwrup_sys_rst_n_release", sys_rst_n, 1);
        checkOutput("pwrup_busy", busy, 0);
      end
    end
    lock_force = 1'b0;

    for (int v = 0; v < 4; v++) begin
      rd0 = rd_total; wr0 = wr_total;
      applyStimulus(v, e2d, r2d);
      checkOutput("seq_err", err, 0);
      checkOutput("seq_reads", rd_total - rd0, NUM_REGS);
      checkOutput("seq_writes", wr_total - wr0, NUM_REGS);
      waitSysRelease("seq_sys_release");
    end

    $display("[TB] DRP timeout");
    rdy_enable = 1'b0;
    applyStimulus(1, e2d, r2d);
    checkOutput("drp_tmo_cycles", e2d, DRP_TIMEOUT + 1);
    checkOutput("drp_tmo_err", err, 1);
    checkOutput("drp_tmo_mmcm_rst", mmcm_rst, 0);
    checkOutput("drp_tmo_busy", busy, 0);
    rdy_enable = 1'b1;
    waitSysRelease("drp_tmo_sys_release");

    $display("[TB] lock timeout");
    lock_force = 1'b1; lock_val = 1'b0;
    applyStimulus(2, e2d, r2d);
    checkOutput("lock_tmo_cycles", r2d, LOCK_TIMEOUT + 1);
    checkOutput("lock_tmo_err", err, 1);
    checkOutput("lock_tmo_sys_rst_n", sys_rst_n, 0);
    checkOutput("lock_tmo_mmcm_rst", mmcm_rst, 0);
    lock_force = 1'b0;
    waitSysRelease("lock_tmo_sys_release");

    $display("[TB] cfg_req while busy");
    rd0 = rd_total; wr0 = wr_total;
    fork
      applyStimulus(0, e2d, r2d);
      begin
        n = 0;
        while (!drp_en && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        cfg_sel = 2'd3;
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
      end
    join
    checkOutput("ignored_req_err_cleared", err, 0);
    checkOutput("ignored_req_reads", rd_total - rd0, NUM_REGS);
    checkOutput("ignored_req_writes", wr_total - wr0, NUM_REGS);
    seen_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    checkOutput("ignored_req_no_queue", seen_busy, 0);
    waitSysRelease("ignored_req_sys_release");

    $display("[TB] lock loss in idle");
    lock_force = 1'b1; lock_val = 1'b1;
    @(negedge clk);
    lock_val = 1'b0;
    saw = 1'b0; low_cnt = 0;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      if (j == 1) lock_val = 1'b1;
      if (!sys_rst_n) begin
        saw = 1'b1;
        low_cnt++;
      end
    end
    checkOutput("lock_loss_sys_rst_n_drop", saw, 1);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (sys_rst_n) break;
      low_cnt++;
    end
    checkOutput("lock_loss_resettle_cycles", low_cnt, SETTLE);
    lock_force = 1'b0;

    $display("[TB] reset during WR");
    loadProfile(3);
    @(negedge clk);
    cfg_sel = vecs[3].sel;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 400) begin
      @(negedge clk);
      n++;
      if (drp_en && drp_we) found = 1'b1;
    end
    checkOutput("abort_reached_wr", found, 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitSysRelease("abort_sys_release");
    checkOutput("abort_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
